// File: rtl/memgather_pkg.sv
// Shared encodings and state type for the read-side width gatherer.
// Imported by memgather and memgather_lane.
package memgather_pkg;

    localparam int PHRASE_BYTES = 8;

    localparam logic [1:0] MW_8  = 2'd0;
    localparam logic [1:0] MW_16 = 2'd1;
    localparam logic [1:0] MW_32 = 2'd2;
    localparam logic [1:0] MW_64 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/memgather_lane.sv
// Per-cycle calculator: bytes served, lane mask, last flag and lane per served byte.
// Purely combinational; sel[j] is the memory lane that carries the j-th byte of this cycle.
module memgather_lane
    import memgather_pkg::*;
(
    input  logic [2:0]      at,
    input  logic [3:0]      n,
    input  logic [1:0]      mw,
    input  logic            bigend,
    output logic [3:0]      c,
    output logic [7:0]      bm,
    output logic            lastc,
    output logic [7:0][2:0] sel
);

    logic [2:0] mask;
    logic [3:0] room;
    logic [2:0] a;

    always_comb begin
        mask  = 3'((4'd1 << mw) - 4'd1);
        room  = (4'd1 << mw) - {1'b0, at & mask};
        c     = (room < n) ? room : n;
        lastc = (c == n);
        bm    = '0;
        sel   = '0;
        a     = '0;
        for (int j = 0; j < PHRASE_BYTES; j++) begin
            a = at + 3'(j);
            // Big-endian mirrors the byte within its memory word.
            sel[j] = bigend ? ((a & ~mask) | (mask - (a & mask))) : a;
            if (4'(j) < c) bm[sel[j]] = 1'b1;
        end
    end

endmodule

// File: rtl/memgather.sv
// Sequences narrow memory reads and reassembles a right-justified word of up to 8 bytes.
// rvalid pulses one cycle after the final ack; ack low stalls indefinitely, start ignored while busy.
module memgather
    import memgather_pkg::*;
#(
    parameter bit ZERO_FILL = 1'b1
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  w,
    input  logic [2:0]  ba,
    input  logic [1:0]  mw,
    input  logic        bigend,
    input  logic        ack,
    input  logic [63:0] din,
    output logic        busy,
    output logic [2:0]  at,
    output logic [7:0]  bm,
    output logic        lastc,
    output logic [63:0] rdata,
    output logic        rvalid
);

    state_t state, state_nxt;

    logic [2:0]  at_q;
    logic [3:0]  n_q, n0_q;
    logic [1:0]  mw_q;
    logic        be_q;
    logic [63:0] rdata_q, rdata_nxt;

    logic [3:0]      cyc_c;
    logic [7:0]      cyc_bm;
    logic            cyc_last;
    logic [7:0][2:0] cyc_sel;

    logic        req_ok;
    logic [3:0]  room_ph, n_init;
    logic [3:0]  done_cnt, k, idx;

    memgather_lane u_lane (
        .at     (at_q),
        .n      (n_q),
        .mw     (mw_q),
        .bigend (be_q),
        .c      (cyc_c),
        .bm     (cyc_bm),
        .lastc  (cyc_last),
        .sel    (cyc_sel)
    );

    assign req_ok  = (w != 4'd0) && (w <= 4'd8);
    assign room_ph = 4'd8 - {1'b0, ba};
    assign n_init  = (w < room_ph) ? w : room_ph;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = req_ok ? RUN : DONE;
            RUN:     if (ack && cyc_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata_nxt = rdata_q;
        done_cnt  = n0_q - n_q;
        k         = '0;
        idx       = '0;
        if (state == IDLE && start) begin
            if (!req_ok) begin
                rdata_nxt = '0;
            end else if (ZERO_FILL) begin
                for (int b = 0; b < PHRASE_BYTES; b++)
                    if (4'(b) >= n_init) rdata_nxt[b*8 +: 8] = 8'h00;
            end
        end else if (state == RUN && ack) begin
            for (int j = 0; j < PHRASE_BYTES; j++) begin
                if (4'(j) < cyc_c) begin
                    k   = done_cnt + 4'(j);
                    // Big-endian results are right-justified with the first byte most significant.
                    idx = be_q ? (n0_q - 4'd1 - k) : k;
                    rdata_nxt[{idx[2:0], 3'b000} +: 8] = din[{cyc_sel[j], 3'b000} +: 8];
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state   <= IDLE;
            at_q    <= '0;
            n_q     <= '0;
            n0_q    <= '0;
            mw_q    <= MW_8;
            be_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            rdata_q <= rdata_nxt;
            if (state == IDLE && start && req_ok) begin
                at_q <= ba;
                n_q  <= n_init;
                n0_q <= n_init;
                mw_q <= mw;
                be_q <= bigend;
            end else if (state == RUN && ack) begin
                at_q <= at_q + cyc_c[2:0];
                n_q  <= n_q - cyc_c;
            end
        end
    end

    assign busy   = (state != IDLE);
    assign at     = at_q;
    assign bm     = (state == RUN) ? cyc_bm : 8'h00;
    assign lastc  = (state == RUN) ? cyc_last : 1'b0;
    assign rdata  = rdata_q;
    assign rvalid = (state == DONE);

endmodule
